// File: rtl/buzzer_seq_pkg.sv
// Shared definitions for the buzzer sequencer: register map, CTRL/STATUS bit
// positions, DUR field placement and the sequencer state encoding.
package buzzer_seq_pkg;

    localparam int unsigned ADDR_W = 2;

    // Word addresses of the slave registers
    localparam logic [ADDR_W-1:0] ADDR_CTRL = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_TONE = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_DUR  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_REP  = 2'd3;

    // CTRL write bits (START/STOP/DONE_CLR are pulses, IRQ_EN is stored)
    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_STOP     = 1;
    localparam int unsigned CTRL_DONE_CLR = 2;
    localparam int unsigned CTRL_IRQ_EN   = 3;

    // STATUS read bits (IRQ_EN reads back at CTRL_IRQ_EN)
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;

    // OFF_TICKS starts at this bit of the DUR register
    localparam int unsigned DUR_OFF_LSB = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/buzzer_tone_gen.sv
// Duration tick prescaler plus square-wave tone generator.
//   clk, reset_n : clock, async active-low reset
//   restart      : state change on this edge; both counters restart
//   enable       : the state being entered/held is ON (tone runs)
//   tone_half    : half-period of the tone in clk cycles (nonzero while enabled)
//   tick_c       : one-cycle pulse every TICK_DIV cycles after the last restart
//   tone         : registered tone level; 1 on the first enabled cycle, 0 when disabled
module buzzer_tone_gen #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             enable,
    input  logic [CNT_W-1:0] tone_half,
    output logic             tick_c,
    output logic             tone
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] half_cnt_q;
    logic             tone_q;

    assign tick_c = (div_cnt_q == DIV_W'(TICK_DIV - 1));
    assign tone   = tone_q;

    // Prescaler: restarts on state entry so each dwell is an exact tick multiple
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else if (restart || tick_c) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Tone: forced low outside ON, starts high on entry, flips every tone_half cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (!enable) begin
            half_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (restart) begin
            half_cnt_q <= '0;
            tone_q     <= 1'b1;
        end else if (half_cnt_q == tone_half - CNT_W'(1)) begin
            half_cnt_q <= '0;
            tone_q     <= ~tone_q;
        end else begin
            half_cnt_q <= half_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Avalon-MM buzzer pattern sequencer: beeps of a programmable tone separated by
// silences, repeated REPEAT times, with a level interrupt on completion.
//   clk, reset_n          : clock, async active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write side (word addressed)
//   readdata              : combinational read data, zero wait states
//   out_port              : registered buzzer drive
//   irq                   : registered level interrupt, DONE & IRQ_EN
module buzzer_sequencer
    import buzzer_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              out_port,
    output logic              irq
);

    // Bus-facing configuration registers
    logic [CNT_W-1:0] tone_cfg_q, on_cfg_q, off_cfg_q, rep_cfg_q;
    logic             irq_en_q, done_q, irq_q;

    // Working copies taken at START, plus dwell tick counter
    logic [CNT_W-1:0] tone_w_q, on_w_q, off_w_q, rem_q, tick_cnt_q;

    seq_state_t state_q, state_d;

    logic wr_c, ctrl_wr_c, start_c, stop_c, done_clr_c, fields_ok_c;
    logic tick_c, dwell_done_c;
    logic busy_c, launch_c, complete_c, advance_c, restart_c, tone_en_c;
    logic done_d, irq_en_d;
    logic unused_c;

    assign wr_c        = chipselect & ~write_n;
    assign ctrl_wr_c   = wr_c && (address == ADDR_CTRL);
    assign start_c     = ctrl_wr_c & writedata[CTRL_START];
    assign stop_c      = ctrl_wr_c & writedata[CTRL_STOP];
    assign done_clr_c  = ctrl_wr_c & writedata[CTRL_DONE_CLR];
    assign fields_ok_c = (|tone_cfg_q) && (|on_cfg_q) && (|rep_cfg_q);
    assign unused_c    = &{1'b0, writedata};

    // Configuration registers: always writable, only sampled by the FSM at START
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tone_cfg_q <= '0;
            on_cfg_q   <= '0;
            off_cfg_q  <= '0;
            rep_cfg_q  <= '0;
        end else if (wr_c) begin
            case (address)
                ADDR_TONE: tone_cfg_q <= writedata[CNT_W-1:0];
                ADDR_DUR: begin
                    on_cfg_q  <= writedata[CNT_W-1:0];
                    off_cfg_q <= writedata[DUR_OFF_LSB +: CNT_W];
                end
                ADDR_REP:  rep_cfg_q  <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Dwell end: last tick of ON/OFF; an empty OFF ends on its single cycle
    always_comb begin
        dwell_done_c = 1'b0;
        case (state_q)
            ON:  dwell_done_c = tick_c && (tick_cnt_q == on_w_q - CNT_W'(1));
            OFF: dwell_done_c = (off_w_q == '0) ||
                                (tick_c && (tick_cnt_q == off_w_q - CNT_W'(1)));
            default: dwell_done_c = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; STOP overrides everything
    always_comb begin
        state_d = state_q;
        if (stop_c) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_c && fields_ok_c) state_d = ON;
                ON:   if (dwell_done_c) state_d = (rem_q > CNT_W'(1)) ? OFF : IDLE;
                OFF:  if (dwell_done_c) state_d = ON;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs (transition strobes)
    always_comb begin
        busy_c     = (state_q != IDLE);
        launch_c   = (state_q == IDLE) && (state_d == ON);
        complete_c = (state_q == ON) && (state_d == IDLE) && !stop_c;
        advance_c  = (state_q == ON) && (state_d == OFF);
        restart_c  = (state_d != state_q);
        tone_en_c  = (state_d == ON);
    end

    // Snapshot, remaining-beep and tick counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tone_w_q   <= '0;
            on_w_q     <= '0;
            off_w_q    <= '0;
            rem_q      <= '0;
            tick_cnt_q <= '0;
        end else begin
            if (launch_c) begin
                tone_w_q <= tone_cfg_q;
                on_w_q   <= on_cfg_q;
                off_w_q  <= off_cfg_q;
                rem_q    <= rep_cfg_q;
            end else if (advance_c) begin
                rem_q <= rem_q - CNT_W'(1);
            end
            if (restart_c) begin
                tick_cnt_q <= '0;
            end else if (tick_c && busy_c) begin
                tick_cnt_q <= tick_cnt_q + CNT_W'(1);
            end
        end
    end

    // DONE: completion set beats DONE_CLR; an accepted START clears it
    always_comb begin
        done_d = done_q;
        if (complete_c) begin
            done_d = 1'b1;
        end else if (done_clr_c || launch_c) begin
            done_d = 1'b0;
        end
        irq_en_d = ctrl_wr_c ? writedata[CTRL_IRQ_EN] : irq_en_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
        end
    end

    assign irq = irq_q;

    buzzer_tone_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tone_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .restart   (restart_c),
        .enable    (tone_en_c),
        .tone_half (tone_w_q),
        .tick_c    (tick_c),
        .tone      (out_port)
    );

    // Read mux, no side effects
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[STAT_BUSY]   = busy_c;
                readdata[STAT_DONE]   = done_q;
                readdata[CTRL_IRQ_EN] = irq_en_q;
            end
            ADDR_TONE: readdata[CNT_W-1:0] = tone_cfg_q;
            ADDR_DUR: begin
                readdata[CNT_W-1:0]           = on_cfg_q;
                readdata[DUR_OFF_LSB +: CNT_W] = off_cfg_q;
            end
            ADDR_REP:  readdata[CNT_W-1:0] = rep_cfg_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench for buzzer_sequencer: expected out_port waveforms are built
// from the pattern rules and queued at START; a negedge monitor pops and compares.
module tb_buzzer_sequencer;
    import buzzer_seq_pkg::*;

    localparam int unsigned TD = 4;
    localparam int unsigned CW = 16;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    bit pat_q[$];
    bit irq_en_m = 1'b0;

    buzzer_sequencer #(.TICK_DIV(TD), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected out_port sample per cycle while the scoreboard is non-empty
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            bit e;
            e = exp_q.pop_front();
            check("out_port", 32'(out_port), 32'(e));
        end
    end

    // Reference waveform: beep i-th cycle is high when (i / tone) is even
    task automatic build_pattern(input int tone, input int on, input int off, input int rep);
        pat_q.delete();
        for (int r = 0; r < rep; r++) begin
            for (int i = 0; i < on * int'(TD); i++) pat_q.push_back(((i / tone) % 2) == 0);
            if (r < rep - 1) begin
                int n;
                n = (off == 0) ? 1 : off * int'(TD);
                for (int k = 0; k < n; k++) pat_q.push_back(1'b0);
            end
        end
    endtask

    task automatic push_expect(input int keep, input int trail);
        for (int i = 0; i < pat_q.size(); i++) begin
            if (keep < 0 || i < keep) exp_q.push_back(pat_q[i]);
        end
        for (int i = 0; i < trail; i++) exp_q.push_back(1'b0);
    endtask

    function automatic logic [31:0] ctrl(input bit start, input bit stop, input bit clr);
        return {28'd0, irq_en_m, clr, stop, start};
    endfunction

    function automatic logic [31:0] stat(input bit busy, input bit done);
        return {28'd0, irq_en_m, 1'b0, done, busy};
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic cfg(input int tone, input int on, input int off, input int rep);
        bus_write(ADDR_TONE, 32'(tone));
        bus_write(ADDR_DUR, {16'(off), 16'(on)});
        bus_write(ADDR_REP, 32'(rep));
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        check({name, " drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pattern(input int tone, input int on, input int off, input int rep, input string name);
        cfg(tone, on, off, rep);
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        build_pattern(tone, on, off, rep);
        push_expect(-1, 3);
        wait_drain(name);
        read_check(ADDR_CTRL, stat(0, 1), {name, " status"});
        check({name, " irq"}, 32'(irq), 32'(irq_en_m));
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #23;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        read_check(ADDR_CTRL, 32'd0, "reset status");
        read_check(ADDR_DUR, 32'd0, "reset dur");
        check("reset out_port", 32'(out_port), 32'd0);
        check("reset irq", 32'(irq), 32'd0);

        // Reset mid-pattern: asserted during the fifth ON cycle (tone high)
        cfg(2, 3, 2, 2);
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        repeat (4) @(posedge clk);
        #2;
        check("pre-reset out_port", 32'(out_port), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset out_port", 32'(out_port), 32'd0);
        read_check(ADDR_TONE, 32'd0, "async reset tone reg");
        read_check(ADDR_CTRL, 32'd0, "async reset status");
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        read_check(ADDR_CTRL, 32'd0, "post-reset status");

        // Basic pattern with IRQ; shadowed config writes and START while busy
        irq_en_m = 1'b1;
        cfg(2, 3, 2, 2);
        read_check(ADDR_DUR, 32'h0002_0003, "dur readback");
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        build_pattern(2, 3, 2, 2);
        push_expect(-1, 3);
        read_check(ADDR_CTRL, stat(1, 0), "basic busy");
        repeat (4) @(posedge clk);
        cfg(5, 1, 2, 2);
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        wait_drain("basic");
        read_check(ADDR_CTRL, stat(0, 1), "basic status");
        check("basic irq", 32'(irq), 32'd1);
        bus_write(ADDR_CTRL, ctrl(0, 0, 1));
        read_check(ADDR_CTRL, stat(0, 0), "done_clr status");
        check("done_clr irq", 32'(irq), 32'd0);

        // Next START picks up the values written mid-pattern
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        build_pattern(5, 1, 2, 2);
        push_expect(-1, 3);
        wait_drain("shadow");
        read_check(ADDR_CTRL, stat(0, 1), "shadow status");

        // Zero-field guard: DONE stays set, nothing starts
        cfg(2, 3, 2, 0);
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        pat_q.delete();
        push_expect(-1, 6);
        wait_drain("rep0");
        read_check(ADDR_CTRL, stat(0, 1), "rep0 status");
        cfg(0, 3, 2, 2);
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        push_expect(-1, 6);
        wait_drain("tone0");
        read_check(ADDR_CTRL, stat(0, 1), "tone0 status");

        // Abort: STOP lands after five ON cycles
        cfg(2, 3, 2, 2);
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        build_pattern(2, 3, 2, 2);
        push_expect(5, 4);
        repeat (3) @(posedge clk);
        bus_write(ADDR_CTRL, ctrl(0, 1, 0));
        wait_drain("stop");
        read_check(ADDR_CTRL, stat(0, 0), "stop status");
        check("stop irq", 32'(irq), 32'd0);
        bus_write(ADDR_CTRL, ctrl(1, 1, 0));
        pat_q.delete();
        push_expect(-1, 6);
        wait_drain("start+stop");
        read_check(ADDR_CTRL, stat(0, 0), "start+stop status");

        // OFF=0: single silent cycle between beeps
        run_pattern(2, 1, 0, 3, "off0");
        bus_write(ADDR_CTRL, ctrl(0, 0, 1));

        // TONE=1 and DONE_CLR coinciding with completion
        cfg(1, 1, 0, 1);
        bus_write(ADDR_CTRL, ctrl(1, 0, 0));
        build_pattern(1, 1, 0, 1);
        push_expect(-1, 3);
        repeat (pat_q.size() - 2) @(posedge clk);
        bus_write(ADDR_CTRL, ctrl(0, 0, 1));
        wait_drain("clr-race");
        read_check(ADDR_CTRL, stat(0, 1), "clr-race status");
        bus_write(ADDR_CTRL, ctrl(0, 0, 1));
        read_check(ADDR_CTRL, stat(0, 0), "clr after race");

        // Randomized patterns
        for (int it = 0; it < 6; it++) begin
            int t, on, off, rep;
            t        = int'($urandom_range(1, 4));
            on       = int'($urandom_range(1, 3));
            off      = int'($urandom_range(0, 2));
            rep      = int'($urandom_range(1, 3));
            irq_en_m = 1'($urandom_range(0, 1));
            run_pattern(t, on, off, rep, "rand");
            bus_write(ADDR_CTRL, ctrl(0, 0, 1));
            read_check(ADDR_CTRL, stat(0, 0), "rand clr");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
